// File: rtl/level_display.sv
// Four-digit multiplexed seven-segment driver for the output-level meter.
// Latches BCD digits every HOLD_CYCLES, blanks leading zeros, scans with an anti-ghost gap.
module level_display #(
    parameter int SCAN_DIV     = 48,
    parameter int BLANK_CYCLES = 4,
    parameter int HOLD_CYCLES  = 12000,
    parameter int DP_POS       = 3
) (
    input  logic       clk_48,
    input  logic       reset_n,
    input  logic [3:0] num3,
    input  logic [3:0] num2,
    input  logic [3:0] num1,
    input  logic [3:0] num0,
    input  logic       freeze,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       updated
);
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [1:0]    DP_IDX    = 2'(DP_POS);
    localparam logic          BLANK3_OK = (DP_POS < 3);
    localparam logic          BLANK2_OK = (DP_POS < 2);
    localparam logic          BLANK1_OK = (DP_POS < 1);

    logic [SW-1:0] scan_cnt;
    logic [HW-1:0] hold_cnt;
    logic [1:0]    digit_idx;
    logic [3:0]    d3, d2, d1, d0;
    logic          blank3, blank2, blank1;
    logic [3:0]    cur_digit;
    logic          cur_blank;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h3F;
        endcase
    endfunction

    // Blanking stops at the decimal-point digit so "0.005" never loses its leading 0.
    assign blank3 = BLANK3_OK && (d3 == 4'd0);
    assign blank2 = blank3 && BLANK2_OK && (d2 == 4'd0);
    assign blank1 = blank2 && BLANK1_OK && (d1 == 4'd0);

    always_comb begin
        cur_digit = d0;
        cur_blank = 1'b0;
        case (digit_idx)
            2'd3: begin cur_digit = d3; cur_blank = blank3; end
            2'd2: begin cur_digit = d2; cur_blank = blank2; end
            2'd1: begin cur_digit = d1; cur_blank = blank1; end
            default: begin cur_digit = d0; cur_blank = 1'b0; end
        endcase
    end

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt  <= '0;
            hold_cnt  <= '0;
            digit_idx <= 2'd0;
            d3        <= 4'd0;
            d2        <= 4'd0;
            d1        <= 4'd0;
            d0        <= 4'd0;
            seg_n     <= 7'h7F;
            dp_n      <= 1'b1;
            an_n      <= 4'hF;
            updated   <= 1'b0;
        end else begin
            updated <= 1'b0;
            if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                if (!freeze) begin
                    d3      <= num3;
                    d2      <= num2;
                    d1      <= num1;
                    d0      <= num0;
                    updated <= 1'b1;
                end
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end

            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end

            // All anodes off at slot start lets the segment lines settle before the next digit.
            if (scan_cnt < BLANK_END) begin
                an_n  <= 4'hF;
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
            end else begin
                an_n  <= ~(4'b0001 << digit_idx);
                seg_n <= cur_blank ? 7'h7F : seg_of(cur_digit);
                dp_n  <= (digit_idx != DP_IDX);
            end
        end
    end
endmodule

// File: doc/level_display.md
Name: level_display

Overview:
- Downstream consumer of the output-level meter's four BCD digits (num3..num0, a ratio scaled ×1000).
- Periodically latches the digits, applies leading-zero blanking up to the decimal-point digit, and drives a 4-digit common-anode multiplexed seven-segment display.
- Includes an anti-ghosting blank interval at every digit change.
- Runs in the 48 kHz sample-clock domain alongside the meter.

Parameters:
- SCAN_DIV, 48: clk cycles per digit slot (48 → 1 kHz slot rate, 250 Hz frame rate); legal range 2..65535.
- BLANK_CYCLES, 4: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- HOLD_CYCLES, 12000: cycles between display latches (matches the meter window); ≥ 1.
- DP_POS, 3: digit index (0..3) whose decimal point is lit; leading-zero blanking never extends to or below this digit.

Ports:
- clk_48  in  1  sample clock.
- reset_n  in  1  asynchronous, active-low reset.
- num3  in  4  BCD digit, thousands (most significant).
- num2  in  4  BCD digit, hundreds.
- num1  in  4  BCD digit, tens.
- num0  in  4  BCD digit, units.
- freeze  in  1  when high, hold ticks do not update the latched digits.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active low.
- dp_n  out  1  decimal point, active low.
- an_n  out  4  digit anodes, active low; bit i selects digit i.
- updated  out  1  one-cycle pulse when the latched digits were refreshed.

Behaviour:
- Reset (async assert, sync release):
  - Outputs: seg_n=7'h7F, dp_n=1, an_n=4'hF, updated=0.
  - Internal: d3..d0=0, scan_cnt=0, digit_idx=0, hold_cnt=0.
- Hold counter:
  - hold_cnt counts 0..HOLD_CYCLES-1 and wraps.
  - On the edge where hold_cnt==HOLD_CYCLES-1 and freeze==0: d3..d0 <= num3..num0 and updated <= 1.
  - updated is 0 on every other edge.
  - freeze high at a tick: the tick is skipped with no latch and no pulse; the counter still wraps.
  - First latch after reset release occurs on the HOLD_CYCLES-th rising edge.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - At the wrap, digit_idx advances 0→1→2→3→0.
  - scan_cnt and hold_cnt are independent.
- Blanking rules:
  - blank3 = (d3==0) && DP_POS<3.
  - blank2 = blank3 && (d2==0) && DP_POS<2.
  - blank1 = blank2 && (d1==0) && DP_POS<1.
  - Digit 0 is never blanked.
  - With DP_POS=3, no digit is ever blanked.
- Decode (d = latched digit at digit_idx):
  - 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 (hex, seg_n).
  - Values 10..15 display a dash (7'h3F).
  - A blanked digit displays 7'h7F.
- Output register (all outputs registered, 1-cycle latency from the counter state):
  - If scan_cnt < BLANK_CYCLES: an_n <= 4'hF, seg_n <= 7'h7F, dp_n <= 1.
  - Otherwise: an_n <= ~(4'b1 << digit_idx), seg_n <= decode, dp_n <= ~(digit_idx==DP_POS).
  - A blanked digit still shows its DP when digit_idx==DP_POS. This cannot occur by construction of the blanking rules.
- Latched digits change only on hold ticks. A tick coinciding with a slot boundary takes effect in the next output register update.
- Reset mid-scan: everything returns to reset values immediately; scanning restarts at digit 0, slot start (blank interval).

Test Plan:
- Params SCAN_DIV=8, BLANK_CYCLES=2, HOLD_CYCLES=20. Inputs 1,2,3,4 (num3..num0) -> updated pulses on edge 20; thereafter digit3 slot shows seg_n=79 with dp_n=0, digit0 shows 19; an_n=F for exactly 2 cycles at each slot start.
- DP_POS=1, inputs 0,0,0,5 -> digits 3 and 2 show 7F with their anodes still cycling; digit1 shows 40 with dp_n=0; digit0 shows 12.
- freeze=1 across a tick with inputs changed from 1,2,3,4 to 9,9,9,9 -> no updated pulse, display unchanged; next tick with freeze=0 latches 9s (seg_n=10).
- num1=4'hC latched -> digit1 shows 3F; other digits decode normally.
- Assert reset_n low mid-slot on digit 2 -> outputs go 7F/1/F asynchronously; after release the first active anode is an_n=E after BLANK_CYCLES+1 edges.
- Run 4×SCAN_DIV cycles -> each an_n value E, D, B, 7 is observed for SCAN_DIV-BLANK_CYCLES cycles; never more than one anode low.
